approx_mult_err_monitor: RTL and testbench
==========================================

Name: approx_mult_err_monitor

Overview:
- Sequential error-statistics engine that sits directly downstream of the 8-bit approximate (4:2-compressor Dadda) multipliers.
- Each input sample carries the operands A and B plus the approximate product P from the multiplier under test.
- The block forms the exact product internally and accumulates, over a programmed number of samples:
  - error count
  - error-distance sum (for mean ED)
  - maximum ED and the operand pair that produced it
- Used for on-chip/FPGA characterisation sweeps of each compressor variant.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- CNT_W, 17, width of sample counters; must hold 2^(2*WIDTH) for an exhaustive sweep.
- ACC_W, 32, width of the ED sum accumulator.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; clears statistics and begins a run.
- num_samples  input  CNT_W  samples to accept; sampled on start.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_p  input  2*WIDTH  approximate product.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE until the next start.
- samples_seen  output  CNT_W  samples accepted this run.
- err_count  output  CNT_W  samples with P != A*B.
- ed_sum  output  ACC_W  sum of |A*B - P|, saturating.
- ed_max  output  2*WIDTH  largest ED this run.
- max_a  output  WIDTH  A of the first sample reaching ed_max.
- max_b  output  WIDTH  B of the first sample reaching ed_max.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - All outputs 0, including in_ready, busy and done.
  - Pipeline valid bits cleared.
  - Reset mid-run discards everything with no partial results retained.
- Pipeline, two stages:
  - S1 registers a, b, p and exact = a*b; unsigned, full 2*WIDTH.
  - S2 computes ed = (exact >= p) ? exact-p : p-exact and updates statistics on the same edge.
- Statistics update per S2-valid sample:
  - ed != 0: err_count+1.
  - ed_sum += ed, saturating at 2^ACC_W-1 with no wrap.
  - ed > ed_max (strictly): ed_max = ed, max_a/max_b = that sample's operands. Ties keep the earlier sample.
- Handshake:
  - Transfer occurs when in_valid && in_ready on a rising edge.
  - in_ready = (state==RUN) && (samples_seen < target).
  - in_ready does not depend on in_valid.
  - samples_seen increments on each transfer.
- States:
  - IDLE: wait for start.
  - RUN: accept samples. When samples_seen reaches target (including on the transfer edge of the last sample), go to DRAIN.
  - DRAIN: in_ready=0. When S1 and S2 are both empty, go to DONE.
  - DONE: done=1, statistics held stable.
- Latency: for the last transfer at edge E, its statistics update at E+1 and done rises at E+2.
- start handling:
  - start in IDLE or DONE clears all statistics and samples_seen, latches target=num_samples, and enters RUN; done falls on that edge.
  - start in RUN or DRAIN is ignored; target stays as latched.
  - start with num_samples=0: RUN immediately moves to DRAIN then DONE; done rises 2 cycles after start; all statistics 0.
- in_valid while not in_ready: ignored; the producer holds its data.
- Outputs are registered and update only on the S2 edge (statistics) or the transfer edge (samples_seen).

Test Plan:
- Reset mid-RUN after 3 transfers -> all outputs 0, state IDLE; a subsequent start runs cleanly.
- start with num_samples=4 and exact samples (3,5,15), (255,255,65025), (0,7,0), (128,2,256) -> done, samples_seen=4, err_count=0, ed_sum=0, ed_max=0, max_a=0, max_b=0.
- num_samples=3 with (255,255,65000), (10,10,110), (200,3,575) -> err_count=3, ed_sum=25+10+25=60, ed_max=25, max_a=255, max_b=255 (tie keeps first); done 2 cycles after the third transfer.
- in_valid held high for 10 cycles with num_samples=2 -> exactly 2 transfers; in_ready drops on the second transfer edge; busy high until done.
- Exhaustive sweep: num_samples=65536, all A,B pairs, P=A*B+1 -> err_count=65536, ed_sum=65536, ed_max=1, max_a=0, max_b=0; the counter does not overflow.
- start pulsed during DRAIN and num_samples=0 start -> DRAIN start ignored; the zero-sample run gives done 2 cycles after start, all statistics 0.

Source files
------------

// File: rtl/approx_mult_err_monitor.sv
// Error-statistics engine for approximate 8-bit multipliers: accumulates error count,
// ED sum (saturating), and max ED with its operands over a programmed number of samples.
module approx_mult_err_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 17,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2*WIDTH-1:0]   in_p,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     samples_seen,
  output logic [CNT_W-1:0]     err_count,
  output logic [ACC_W-1:0]     ed_sum,
  output logic [2*WIDTH-1:0]   ed_max,
  output logic [WIDTH-1:0]     max_a,
  output logic [WIDTH-1:0]     max_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                state;
  logic [CNT_W-1:0]      target;
  logic                  s1_valid;
  logic [WIDTH-1:0]      s1_a;
  logic [WIDTH-1:0]      s1_b;
  logic [2*WIDTH-1:0]    s1_p;
  logic [2*WIDTH-1:0]    s1_exact;
  logic [2*WIDTH-1:0]    ed;
  logic [ACC_W:0]        sum_ext;
  logic                  xfer;
  logic                  run_full;

  assign in_ready = (state == RUN) && (samples_seen < target);
  assign xfer     = in_valid && in_ready;

  // Target reached either already or by the transfer happening on this edge.
  assign run_full = (samples_seen >= target) ||
                    (xfer && ((samples_seen + CNT_ONE) == target));

  always_comb begin
    ed      = (s1_exact >= s1_p) ? (s1_exact - s1_p) : (s1_p - s1_exact);
    sum_ext = {1'b0, ed_sum} + (ACC_W+1)'(ed);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      target       <= '0;
      s1_valid     <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_p         <= '0;
      s1_exact     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      samples_seen <= '0;
      err_count    <= '0;
      ed_sum       <= '0;
      ed_max       <= '0;
      max_a        <= '0;
      max_b        <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_p     <= in_p;
        s1_exact <= {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
      end

      if (s1_valid) begin
        if (ed != '0) err_count <= err_count + CNT_ONE;
        ed_sum <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        if (ed > ed_max) begin
          ed_max <= ed;
          max_a  <= s1_a;
          max_b  <= s1_b;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            target       <= num_samples;
            busy         <= 1'b1;
            done         <= 1'b0;
            samples_seen <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            ed_max       <= '0;
            max_a        <= '0;
            max_b        <= '0;
          end
        end
        RUN: begin
          if (xfer) samples_seen <= samples_seen + CNT_ONE;
          if (run_full) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor with hand-computed statistics.
module tb_approx_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [16:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [15:0] in_p = '0;
  logic        busy;
  logic        done;
  logic [16:0] samples_seen;
  logic [16:0] err_count;
  logic [31:0] ed_sum;
  logic [15:0] ed_max;
  logic [7:0]  max_a;
  logic [7:0]  max_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  approx_mult_err_monitor #(.WIDTH(8), .CNT_W(17), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .busy(busy), .done(done), .samples_seen(samples_seen), .err_count(err_count),
    .ed_sum(ed_sum), .ed_max(ed_max), .max_a(max_a), .max_b(max_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [16:0] n);
    start = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    int unsigned n;
    n = 0;
    in_a = a; in_b = b; in_p = p; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic check_stats(input string tag, input logic [16:0] seen, input logic [16:0] errs,
                             input logic [31:0] sum, input logic [15:0] mx,
                             input logic [7:0] ma, input logic [7:0] mb);
    check({tag, "_seen"}, samples_seen, seen);
    check({tag, "_err"},  err_count, errs);
    check({tag, "_sum"},  ed_sum, sum);
    check({tag, "_max"},  ed_max, mx);
    check({tag, "_ma"},   max_a, ma);
    check({tag, "_mb"},   max_b, mb);
  endtask

  initial begin
    int unsigned xfers;
    logic        r;

    // Reset state
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_stats("rst", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-RUN after 3 erroneous transfers
    do_start(17'd10);
    check("run_busy", busy, 1);
    push(8'd1, 8'd1, 16'd5);
    push(8'd2, 8'd2, 16'd9);
    push(8'd3, 8'd3, 16'd1);
    check("mid_seen", samples_seen, 3);
    rst_n = 1'b0;
    #1;
    check("mrst_ready", in_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check_stats("mrst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Four exact samples
    do_start(17'd4);
    push(8'd3, 8'd5, 16'd15);
    push(8'd255, 8'd255, 16'd65025);
    push(8'd0, 8'd7, 16'd0);
    push(8'd128, 8'd2, 16'd256);
    wait_done(20);
    check_stats("exact", 4, 0, 0, 0, 0, 0);

    // Three erroneous samples, tie on ED=25 keeps first; done exactly 2 cycles after last transfer
    do_start(17'd3);
    check("restart_done", done, 0);
    push(8'd255, 8'd255, 16'd65000);
    push(8'd10, 8'd10, 16'd110);
    push(8'd200, 8'd3, 16'd575);
    check("lat_e0_done", done, 0);
    @(negedge clk);
    check("lat_e1_done", done, 0);
    check("lat_e1_sum", ed_sum, 60);
    @(negedge clk);
    check("lat_e2_done", done, 1);
    check_stats("err3", 3, 3, 60, 25, 255, 255);

    // in_valid held for 10 cycles with num_samples=2
    do_start(17'd2);
    in_a = 8'd3; in_b = 8'd4; in_p = 16'd12; in_valid = 1'b1;
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      r = in_ready;
      @(negedge clk);
      if (r) begin
        xfers++;
        if (xfers == 2) begin
          check("ready_drop", in_ready, 0);
          check("busy_drain", busy, 1);
        end
      end
    end
    in_valid = 1'b0;
    check("hold_xfers", xfers, 2);
    check("hold_done", done, 1);
    check("hold_busy", busy, 0);
    check_stats("hold", 2, 0, 0, 0, 0, 0);

    // start during DRAIN ignored
    do_start(17'd1);
    push(8'd4, 8'd4, 16'd20);
    do_start(17'd5);
    check("drain_start_done", done, 0);
    @(negedge clk);
    check("drain_start_done2", done, 1);
    check("drain_start_ready", in_ready, 0);
    check_stats("drain", 1, 1, 4, 4, 4, 4);

    // Zero-sample run
    do_start(17'd0);
    check("zero_e0_busy", busy, 1);
    check("zero_e0_done", done, 0);
    check("zero_e0_ready", in_ready, 0);
    @(negedge clk);
    check("zero_e1_done", done, 0);
    @(negedge clk);
    check("zero_e2_done", done, 1);
    check_stats("zero", 0, 0, 0, 0, 0, 0);

    // Exhaustive sweep, P = A*B + 1
    do_start(17'd65536);
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        push(8'(a), 8'(b), 16'(a * b + 1));
      end
    end
    wait_done(20);
    check_stats("sweep", 17'd65536, 17'd65536, 32'd65536, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
